// File: rtl/expr_eval_sched.sv
// expr_eval_sched: round-robin scheduler sharing one combinational expression unit between requesters
module expr_eval_sched #(
  parameter int NREQ = 4,
  parameter int OPW = 60,
  parameter int YW = 90,
  parameter int SETTLE = 1,
  parameter int CNTW = 16,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OPW-1:0]  req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [OPW-1:0]       eu_opnd,
  input  logic [YW-1:0]        eu_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [YW-1:0]        rsp_y,
  output logic                 busy,
  output logic [CNTW-1:0]      done_cnt
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  typedef enum logic [1:0] {IDLE, SETL, RESP} state_t;
  state_t state, nxt;
  logic [OPW-1:0] op_reg;
  logic [OPW-1:0] dat [NREQ];
  logic [IDW-1:0] rr_ptr, g, hi_g, lo_g;
  logic hi, lo;
  logic [CW-1:0] cnt;
  if (SETTLE < 1) begin : g_settle_chk
    $error("SETTLE must be at least 1");
  end
  genvar i;
  for (i = 0; i < NREQ; i++) begin : g_dat
    assign dat[i] = req_data[i*OPW +: OPW];
  end
  assign eu_opnd = op_reg;
  assign busy = state != IDLE;
  // grant: first valid index at or above rr_ptr, otherwise lowest valid index (wrap-around)
  always_comb begin
    hi = 1'b0;
    lo = 1'b0;
    hi_g = '0;
    lo_g = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo = 1'b1;
        lo_g = IDW'(k);
        if (k >= int'(rr_ptr)) begin
          hi = 1'b1;
          hi_g = IDW'(k);
        end
      end
    end
    g = hi ? hi_g : lo_g;
  end
  // accept strobe and next state
  always_comb begin
    req_ready = '0;
    if (state == IDLE && lo && !rst) req_ready[g] = 1'b1;
    nxt = state == IDLE ? (lo ? SETL : IDLE) :
          state == SETL ? (cnt == '0 ? RESP : SETL) :
          (rsp_ready ? IDLE : RESP);
  end
  // state register, operand latch, result capture and handshake bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_reg <= '0;
      rsp_y <= '0;
      rsp_id <= '0;
      rsp_valid <= 1'b0;
      rr_ptr <= '0;
      done_cnt <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && lo) begin
        op_reg <= dat[g];
        rsp_id <= g;
        cnt <= CW'(SETTLE - 1);
      end
      if (state == SETL) begin
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          rsp_y <= eu_y;
          rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        done_cnt <= &done_cnt ? done_cnt : done_cnt + CNTW'(1);
        rr_ptr <= IDW'((int'(rsp_id) + 1) % NREQ);
      end
    end
  end
endmodule

// File: tb/tb_expr_eval_sched.sv
// tb_expr_eval_sched: directed checks of expr_eval_sched against a cycle-stamped transaction model
module tb_expr_eval_sched;
  logic clk = 1'b0;
  logic rst1, rst2, rr1, rr2, rsv1, rsv2, b1, b2;
  logic [3:0] rv1, rv2, rdy1, rdy2;
  logic [239:0] rd1, rd2;
  logic [59:0] op1, op2;
  logic [89:0] y1, y2, ry1, ry2;
  logic [1:0] id1, id2;
  logic [15:0] dc1;
  logic [3:0] dc2;
  int checks = 0, errors = 0;
  bit en = 0;
  int m_own[2] = '{-1, -1};
  int m_age[2] = '{0, 0};
  int m_ptr[2] = '{0, 0};
  int m_done[2] = '{0, 0};
  logic [59:0] m_op[2] = '{60'd0, 60'd0};
  int sv[2] = '{1, 3};
  int cm[2] = '{65535, 15};
  logic [59:0] last2 = '0;
  int age2 = 0;

  always #5 clk = ~clk;

  expr_eval_sched #(.NREQ(4), .SETTLE(1), .CNTW(16)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(rv1), .req_data(rd1), .req_ready(rdy1),
    .eu_opnd(op1), .eu_y(y1), .rsp_valid(rsv1), .rsp_ready(rr1), .rsp_id(id1),
    .rsp_y(ry1), .busy(b1), .done_cnt(dc1));

  expr_eval_sched #(.NREQ(4), .SETTLE(3), .CNTW(4)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(rv2), .req_data(rd2), .req_ready(rdy2),
    .eu_opnd(op2), .eu_y(y2), .rsp_valid(rsv2), .rsp_ready(rr2), .rsp_id(id2),
    .rsp_y(ry2), .busy(b2), .done_cnt(dc2));

  function automatic logic [89:0] expr(input logic [59:0] o);
    logic [29:0] s;
    s = o[59:30] + o[29:0];
    return {s, 8'({4'd0, o[59:56]} * {4'd0, o[29:26]}), 10'({5'd0, o[55:51]} * {5'd0, o[25:21]}),
            12'({6'd0, o[50:45]} * {6'd0, o[20:15]}), 8'({4'd0, o[44:41]} * {4'd0, o[14:11]}),
            10'({5'd0, o[40:36]} * {5'd0, o[10:6]}), 12'({6'd0, o[35:30]} * {6'd0, o[5:0]})};
  endfunction

  function automatic logic [59:0] mk(input int k);
    return {4'(k + 1), 5'(k + 3), 6'(k * 7 + 1), 4'(k + 5), 5'(k * 3 + 2), 6'(k + 9),
            4'(k + 2), 5'(k + 11), 6'(k * 5 + 3), 4'(k + 7), 5'(k + 1), 6'(k * 2 + 13)};
  endfunction

  assign y1 = expr(op1);
  assign y2 = age2 >= 3 ? expr(op2) : ~expr(op2);

  // second unit only produces a correct result in the third cycle of stable operands
  always @(negedge clk) begin
    if (op2 !== last2) begin
      last2 = op2;
      age2 = 1;
    end else age2 = age2 + 1;
  end

  task automatic cmp(input int d, input string nm, input logic [95:0] a, input logic [95:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut%0d %s got %0h expected %0h at %0t", d + 1, nm, a, e, $time);
    end
  endtask

  task automatic model(input int d, input logic r, input logic [3:0] v, input logic [239:0] data,
                       input logic rr, input logic [3:0] rdy, input logic [59:0] op, input logic rv,
                       input logic [1:0] id, input logic [89:0] y, input logic b, input int dc);
    int gnt;
    logic [1:0] ix;
    logic ev;
    gnt = -1;
    if (m_own[d] < 0)
      for (int k = 0; k < 4; k++) begin
        ix = 2'(m_ptr[d] + k);
        if (gnt < 0 && v[ix]) gnt = int'(ix);
      end
    ev = m_own[d] >= 0 && m_age[d] >= sv[d] + 1;
    cmp(d, "req_ready", rdy, (r || gnt < 0) ? 4'd0 : 4'(1 << gnt));
    cmp(d, "busy", b, m_own[d] >= 0);
    cmp(d, "rsp_valid", rv, ev);
    cmp(d, "eu_opnd", op, m_op[d]);
    cmp(d, "done_cnt", dc, m_done[d]);
    if (ev) begin
      cmp(d, "rsp_id", id, m_own[d]);
      cmp(d, "rsp_y", y, expr(m_op[d]));
    end
    if (r) begin
      m_own[d] = -1;
      m_age[d] = 0;
      m_ptr[d] = 0;
      m_done[d] = 0;
      m_op[d] = '0;
    end else if (m_own[d] < 0) begin
      if (gnt >= 0) begin
        m_own[d] = gnt;
        m_age[d] = 1;
        m_op[d] = 60'(data >> (60 * gnt));
      end
    end else if (ev && rr) begin
      m_done[d] = m_done[d] < cm[d] ? m_done[d] + 1 : cm[d];
      m_ptr[d] = (m_own[d] + 1) % 4;
      m_own[d] = -1;
    end else m_age[d]++;
  endtask

  // every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (en) begin
      model(0, rst1, rv1, rd1, rr1, rdy1, op1, rsv1, id1, ry1, b1, int'(dc1));
      model(1, rst2, rv2, rd2, rr2, rdy2, op2, rsv2, id2, ry2, b2, int'(dc2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gq[$];
    int cq[$];
    int hs;
    bit got15;
    rst1 = 1; rst2 = 1; rv1 = 0; rv2 = 0; rd1 = '0; rd2 = '0; rr1 = 0; rr2 = 0;
    step();
    step();
    en = 1;
    rv1 = 4'hF;
    @(negedge clk);
    cmp(0, "rst_ready", rdy1, 4'd0);
    cmp(0, "rst_busy", b1, 1'b0);
    cmp(0, "rst_valid", rsv1, 1'b0);
    cmp(0, "rst_opnd", op1, 60'd0);
    cmp(0, "rst_y", ry1, 90'd0);
    cmp(0, "rst_id", id1, 2'd0);
    cmp(1, "rst_cnt", dc2, 4'd0);
    step();
    rst1 = 0; rst2 = 0; rv1 = 0;
    // single request from requester 2 with hand-computed result
    step();
    rv1 = 4'b0100;
    rd1 = {60'd0, 4'd2, 26'd0, 4'd3, 26'd0, 120'd0};
    @(negedge clk);
    cmp(0, "t1_ready", rdy1, 4'b0100);
    step();
    rv1 = 0;
    @(negedge clk);
    cmp(0, "t1_ready_off", rdy1, 4'd0);
    cmp(0, "t1_early", rsv1, 1'b0);
    step();
    rr1 = 1;
    @(negedge clk);
    cmp(0, "t1_valid", rsv1, 1'b1);
    cmp(0, "t1_id", id1, 2'd2);
    cmp(0, "t1_y", ry1, {30'h1400_0000, 8'd6, 52'd0});
    step();
    rr1 = 0;
    @(negedge clk);
    cmp(0, "t1_idle", b1, 1'b0);
    step();
    rst1 = 1;
    step();
    rst1 = 0;
    // all four requesting: round-robin order and accept spacing
    rv1 = 4'hF;
    rd1 = {mk(3), mk(2), mk(1), mk(0)};
    rr1 = 1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (rdy1 == 4'(1 << k)) begin
          gq.push_back(k);
          cq.push_back(c);
        end
      step();
    end
    rv1 = 0;
    @(negedge clk);
    cmp(0, "t2_grants", gq.size(), 5);
    for (int n = 0; n < 5; n++) begin
      cmp(0, "t2_order", gq[n], n % 4);
      cmp(0, "t2_cycle", cq[n], 3 * n);
    end
    cmp(0, "t2_done", dc1, 16'd5);
    // consumer stall for ten cycles in RESP
    step();
    rr1 = 0;
    rv1 = 4'b0010;
    @(negedge clk);
    cmp(0, "t3_ready", rdy1, 4'b0010);
    step();
    rv1 = 0;
    step();
    rv1 = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cmp(0, "t3_valid", rsv1, 1'b1);
      cmp(0, "t3_id", id1, 2'd1);
      cmp(0, "t3_y", ry1, expr(mk(1)));
      cmp(0, "t3_opnd", op1, mk(1));
      cmp(0, "t3_noready", rdy1, 4'd0);
      step();
    end
    rr1 = 1;
    step();
    @(negedge clk);
    cmp(0, "t3_release", b1, 1'b0);
    cmp(0, "t3_next", rdy1, 4'b0100);
    step();
    rv1 = 0;
    step();
    step();
    // reset while a transaction is settling
    rv1 = 4'b1000;
    step();
    rv1 = 0;
    rst1 = 1;
    step();
    rst1 = 0;
    rv1 = 4'b1010;
    @(negedge clk);
    cmp(0, "t5_valid", rsv1, 1'b0);
    cmp(0, "t5_busy", b1, 1'b0);
    cmp(0, "t5_id", id1, 2'd0);
    cmp(0, "t5_done", dc1, 16'd0);
    cmp(0, "t5_grant", rdy1, 4'b0010);
    step();
    rv1 = 0;
    step();
    step();
    step();
    // three-cycle settle with a slow expression unit
    rv2 = 4'b0001;
    rd2 = {mk(7), mk(6), mk(5), mk(4)};
    @(negedge clk);
    cmp(1, "t4_ready", rdy2, 4'b0001);
    step();
    rv2 = 0;
    step();
    step();
    @(negedge clk);
    cmp(1, "t4_early", rsv2, 1'b0);
    step();
    rr2 = 1;
    @(negedge clk);
    cmp(1, "t4_valid", rsv2, 1'b1);
    cmp(1, "t4_y", ry2, expr(mk(4)));
    cmp(1, "t4_id", id2, 2'd0);
    step();
    rr2 = 0;
    rst2 = 1;
    step();
    rst2 = 0;
    // done counter saturation with a 4-bit counter
    rv2 = 4'hF;
    rr2 = 1;
    hs = 0;
    got15 = 0;
    for (int c = 0; c < 200 && hs < 17; c++) begin
      @(negedge clk);
      if (hs == 15 && !got15) begin
        got15 = 1;
        cmp(1, "t6_cnt15", dc2, 4'd15);
      end
      if (rsv2) hs++;
      step();
    end
    rv2 = 0;
    cmp(1, "t6_handshakes", hs, 17);
    cmp(1, "t6_seen15", got15, 1'b1);
    @(negedge clk);
    cmp(1, "t6_sat", dc2, 4'd15);
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
